// File: rtl/icache_pkg.sv
// Shared widths, FSM encodings and line payload type for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned REG_DAT_W    = 32;
    localparam int unsigned INS_DAT_W    = 32;
    localparam int unsigned LINE_WORDS   = 4;
    localparam int unsigned BYTE_OFF_W   = 4;
    localparam int unsigned ICACHE_IDX_W = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef logic [LINE_WORDS-1:0][INS_DAT_W-1:0] line_t;

    // Byte address of the first word of the line holding pc.
    function automatic logic [REG_DAT_W-1:0] line_base(input logic [REG_DAT_W-1:0] pc);
        return {pc[REG_DAT_W-1:BYTE_OFF_W], BYTE_OFF_W'(0)};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one full-line write port, bulk valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W = ICACHE_IDX_W,
    parameter int unsigned TAG_W = REG_DAT_W - ICACHE_IDX_W - BYTE_OFF_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output line_t            rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_t            wr_line,
    input  logic             flush
);

    localparam int unsigned LINES = 1 << IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    line_t            data_mem [LINES];

    // Flush wins over a same-cycle line install.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !flush) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped I-cache: one outstanding fetch, hit latency 1, word-by-word 4-word line refill.
// Define ICACHE_STAT_EN to add the oHitCnt/oMissCnt statistics ports.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W = ICACHE_IDX_W
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIF_En,
    input  logic [REG_DAT_W-1:0] iIF_Pc,
    output logic                 oIF_En,
    output logic [INS_DAT_W-1:0] oIF_Ins,
    input  logic                 iFlush,
    output logic                 oMC_En,
    output logic [REG_DAT_W-1:0] oMC_Addr,
    input  logic                 iMC_En,
    input  logic [REG_DAT_W-1:0] iMC_Dat
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]          oHitCnt,
    output logic [31:0]          oMissCnt
`endif
);

    localparam int unsigned TAG_W = REG_DAT_W - IDX_W - BYTE_OFF_W;
    localparam int unsigned IDX_LO = BYTE_OFF_W;
    localparam int unsigned TAG_LO = BYTE_OFF_W + IDX_W;

    logic [1:0]           state, state_d;
    logic [1:0]           wcnt, wcnt_d;
    logic [REG_DAT_W-1:2] pc_q, pc_d;
    line_t                line_buf, buf_d;
    logic                 if_en_d, mc_en_d, line_we;
    logic [INS_DAT_W-1:0] if_ins_d;
    logic [REG_DAT_W-1:0] mc_addr_d;
    logic                 rd_valid, hit;
    logic [TAG_W-1:0]     rd_tag;
    line_t                rd_line;
    logic [1:0]           unused_pc;

    assign unused_pc = iIF_Pc[1:0];

    icache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (iIF_Pc[TAG_LO-1:IDX_LO]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (line_we && en),
        .wr_idx   (pc_q[TAG_LO-1:IDX_LO]),
        .wr_tag   (pc_q[REG_DAT_W-1:TAG_LO]),
        .wr_line  (buf_d),
        .flush    (iFlush && en)
    );

    assign hit = rd_valid && (rd_tag == iIF_Pc[REG_DAT_W-1:TAG_LO]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wcnt     <= 2'd0;
            pc_q     <= '0;
            line_buf <= '0;
            oIF_En   <= 1'b0;
            oIF_Ins  <= '0;
            oMC_En   <= 1'b0;
            oMC_Addr <= '0;
        end else if (en) begin
            state    <= state_d;
            wcnt     <= wcnt_d;
            pc_q     <= pc_d;
            line_buf <= buf_d;
            oIF_En   <= if_en_d;
            oIF_Ins  <= if_ins_d;
            oMC_En   <= mc_en_d;
            oMC_Addr <= mc_addr_d;
        end
    end

    // Next-state and next-output logic; flush overrides everything.
    always_comb begin
        state_d   = state;
        wcnt_d    = wcnt;
        pc_d      = pc_q;
        buf_d     = line_buf;
        if_en_d   = 1'b0;
        if_ins_d  = oIF_Ins;
        mc_en_d   = oMC_En;
        mc_addr_d = oMC_Addr;
        line_we   = 1'b0;
        if (iFlush) begin
            state_d = ST_IDLE;
            mc_en_d = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iIF_En) begin
                        if (hit) begin
                            if_en_d  = 1'b1;
                            if_ins_d = rd_line[iIF_Pc[3:2]];
                        end else begin
                            pc_d      = iIF_Pc[REG_DAT_W-1:2];
                            wcnt_d    = 2'd0;
                            mc_en_d   = 1'b1;
                            mc_addr_d = line_base(iIF_Pc);
                            state_d   = ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (iMC_En && oMC_En) begin
                        buf_d[wcnt] = iMC_Dat;
                        wcnt_d      = wcnt + 2'd1;
                        mc_addr_d   = oMC_Addr + REG_DAT_W'(4);
                        if (wcnt == 2'd3) begin
                            line_we = 1'b1;
                            mc_en_d = 1'b0;
                            state_d = ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if_en_d  = 1'b1;
                    if_ins_d = line_buf[pc_q[3:2]];
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    logic hit_evt, miss_evt;

    assign hit_evt  = en && !iFlush && (state == ST_IDLE) && iIF_En && hit;
    assign miss_evt = en && !iFlush && (state == ST_IDLE) && iIF_En && !hit;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oHitCnt  <= '0;
            oMissCnt <= '0;
        end else begin
            if (hit_evt)  oHitCnt  <= oHitCnt + 32'd1;
            if (miss_evt) oMissCnt <= oMissCnt + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
